// File: rtl/clock_div_pkg.sv
// ---------------------------------------------------------------------------
// clock_div_pkg
// Shared definitions for the multi-channel clock divider:
//   - mode_e         : per-channel output mode (toggle clock / tick only)
//   - CNT_W_DEF      : default counter/divisor width
//   - DEF_DIV_DEF    : default reset divisor
//   - SYS_CLK_HZ     : system clock frequency
//   - div_for_freq() : divisor giving a toggle-mode output of f_hz
// ---------------------------------------------------------------------------
package clock_div_pkg;

  typedef enum logic {
    MODE_TOGGLE = 1'b0,
    MODE_TICK   = 1'b1
  } mode_e;

  localparam int unsigned CNT_W_DEF   = 26;
  localparam int unsigned DEF_DIV_DEF = 500_000;
  localparam int unsigned SYS_CLK_HZ  = 100_000_000;

  // Toggle-mode output period is 2*(N+1) system clocks, so N = Fsys/(2f) - 1.
  // A zero or out-of-range request collapses to N=0 (fastest output).
  function automatic int unsigned div_for_freq(input int unsigned f_hz);
    int unsigned half;
    if (f_hz == 0) return 0;
    half = SYS_CLK_HZ / (2 * f_hz);
    return (half == 0) ? 0 : half - 1;
  endfunction

endpackage

// File: rtl/clock_div_ch.sv
// ---------------------------------------------------------------------------
// clock_div_ch
// One divider channel. Counts 0..N (N = active divisor) while enabled,
// pulsing tick at every wrap and, in toggle mode, flipping clk_out_o.
// Divisor writes while running are held pending until the next wrap so a
// period is never cut short or stretched mid-way.
// Optional macro CLOCK_DIV_MULTI_PHASE_SYNC_EN adds sync_i, which restarts
// the period of an enabled channel exactly like a disable does.
//
// Ports:
//   clk         system clock
//   rst         synchronous active-low reset
//   sync_i      phase-align strobe (only with CLOCK_DIV_MULTI_PHASE_SYNC_EN)
//   en_i        run enable
//   mode_i      MODE_TOGGLE / MODE_TICK
//   div_wr_i    one-cycle divisor write strobe
//   div_i       divisor value written by div_wr_i
//   clk_out_o   divided clock (registered)
//   tick_o      one-cycle wrap pulse (registered)
//   upd_pend_o  a written divisor is waiting for the next wrap
// ---------------------------------------------------------------------------
module clock_div_ch
  import clock_div_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned DEF_DIV = DEF_DIV_DEF
) (
  input  logic             clk,
  input  logic             rst,
`ifdef CLOCK_DIV_MULTI_PHASE_SYNC_EN
  input  logic             sync_i,
`endif
  input  logic             en_i,
  input  mode_e            mode_i,
  input  logic             div_wr_i,
  input  logic [CNT_W-1:0] div_i,
  output logic             clk_out_o,
  output logic             tick_o,
  output logic             upd_pend_o
);

  localparam logic [CNT_W-1:0] DEF_VAL = CNT_W'(DEF_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] act_q, act_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             pend_flag_q, pend_flag_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;

  logic             wrap;
  logic             restart;
  logic [CNT_W-1:0] boundary_div;

  // A restart drops the channel back to the start of a fresh period.
`ifdef CLOCK_DIV_MULTI_PHASE_SYNC_EN
  assign restart = !en_i || sync_i;
`else
  assign restart = !en_i;
`endif

  assign wrap = (cnt_q == act_q);

  // Divisor that takes over at a period boundary: a same-cycle write wins,
  // otherwise whatever was pending, otherwise keep the current one.
  assign boundary_div = div_wr_i    ? div_i  :
                        pend_flag_q ? pend_q : act_q;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    cnt_d       = cnt_q;
    act_d       = act_q;
    pend_d      = div_wr_i ? div_i : pend_q;
    pend_flag_d = pend_flag_q;
    clk_d       = clk_q;
    tick_d      = 1'b0;

    if (restart) begin
      cnt_d       = '0;
      clk_d       = 1'b0;
      act_d       = boundary_div;
      pend_flag_d = 1'b0;
    end else if (wrap) begin
      cnt_d       = '0;
      tick_d      = 1'b1;
      clk_d       = (mode_i == MODE_TOGGLE) ? ~clk_q : 1'b0;
      act_d       = boundary_div;
      pend_flag_d = 1'b0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
      if (mode_i == MODE_TICK) clk_d = 1'b0;
      if (div_wr_i) pend_flag_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q       <= '0;
      act_q       <= DEF_VAL;
      pend_q      <= DEF_VAL;
      pend_flag_q <= 1'b0;
      clk_q       <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      act_q       <= act_d;
      pend_q      <= pend_d;
      pend_flag_q <= pend_flag_d;
      clk_q       <= clk_d;
      tick_q      <= tick_d;
    end
  end

  assign clk_out_o  = clk_q;
  assign tick_o     = tick_q;
  assign upd_pend_o = pend_flag_q;

endmodule

// File: rtl/clock_div_multi.sv
// ---------------------------------------------------------------------------
// clock_div_multi
// NUM_CH independent programmable clock dividers sharing the system clock.
// Each channel is a clock_div_ch; this level only slices the buses.
// Optional macro CLOCK_DIV_MULTI_PHASE_SYNC_EN adds sync_in, which restarts
// every enabled channel on the same edge to phase-align them.
//
// Ports:
//   clk       system clock (100 MHz)
//   rst       synchronous active-low reset
//   sync_in   phase-align strobe (only with CLOCK_DIV_MULTI_PHASE_SYNC_EN)
//   en        per-channel run enable
//   mode      per-channel mode: 0 toggle clock, 1 tick only
//   div_wr    per-channel divisor write strobe
//   div_in    flattened divisors, channel i at [i*CNT_W +: CNT_W]
//   clk_out   per-channel divided clock
//   tick      per-channel one-cycle wrap pulse
//   upd_pend  per-channel pending-divisor flag
// ---------------------------------------------------------------------------
module clock_div_multi
  import clock_div_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned DEF_DIV = DEF_DIV_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
`ifdef CLOCK_DIV_MULTI_PHASE_SYNC_EN
  input  logic                    sync_in,
`endif
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH-1:0]       mode,
  input  logic [NUM_CH-1:0]       div_wr,
  input  logic [NUM_CH*CNT_W-1:0] div_in,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       upd_pend
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clock_div_ch #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
`ifdef CLOCK_DIV_MULTI_PHASE_SYNC_EN
      .sync_i     (sync_in),
`endif
      .en_i       (en[i]),
      .mode_i     (mode_e'(mode[i])),
      .div_wr_i   (div_wr[i]),
      .div_i      (div_in[i*CNT_W +: CNT_W]),
      .clk_out_o  (clk_out[i]),
      .tick_o     (tick[i]),
      .upd_pend_o (upd_pend[i])
    );
  end

endmodule

// File: tb/tb_clock_div_multi.sv
// ---------------------------------------------------------------------------
// tb_clock_div_multi
// Self-checking bench for clock_div_multi (NUM_CH=2, CNT_W=8, DEF_DIV=3).
// A period-based reference model runs alongside every cycle; directed
// tables and sequences check the documented corner cases with constants.
// ---------------------------------------------------------------------------
module tb_clock_div_multi;

  localparam int NUM_CH  = 2;
  localparam int CNT_W   = 8;
  localparam int DEF_DIV = 3;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    sync_in;
  logic [NUM_CH-1:0]       en, mode, div_wr;
  logic [NUM_CH*CNT_W-1:0] div_in;
  logic [NUM_CH-1:0]       clk_out, tick, upd_pend;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clock_div_multi #(
    .NUM_CH  (NUM_CH),
    .CNT_W   (CNT_W),
    .DEF_DIV (DEF_DIV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef CLOCK_DIV_MULTI_PHASE_SYNC_EN
    .sync_in  (sync_in),
`endif
    .en       (en),
    .mode     (mode),
    .div_wr   (div_wr),
    .div_in   (div_in),
    .clk_out  (clk_out),
    .tick     (tick),
    .upd_pend (upd_pend)
  );

  // ---------------- reference model (period view) ----------------
  // elapsed: clocks spent in the current period; a period of divisor N
  // lasts N+1 clocks and ends with a tick.
  int m_elapsed [NUM_CH];
  int m_div     [NUM_CH];
  int m_pval    [NUM_CH];
  bit m_pend    [NUM_CH];
  bit m_level   [NUM_CH];
  bit m_tick    [NUM_CH];

  task automatic model_step();
    for (int c = 0; c < NUM_CH; c++) begin
      int din;
      bit restart;
      din = int'(div_in[c*CNT_W +: CNT_W]);
      restart = !en[c];
`ifdef CLOCK_DIV_MULTI_PHASE_SYNC_EN
      restart = restart || sync_in;
`endif
      if (!rst) begin
        m_elapsed[c] = 0; m_div[c] = DEF_DIV; m_pval[c] = DEF_DIV;
        m_pend[c] = 0; m_level[c] = 0; m_tick[c] = 0;
      end else if (restart) begin
        m_elapsed[c] = 0; m_level[c] = 0; m_tick[c] = 0;
        if (div_wr[c]) begin m_div[c] = din; m_pval[c] = din; end
        else if (m_pend[c]) m_div[c] = m_pval[c];
        m_pend[c] = 0;
      end else begin
        m_elapsed[c]++;
        if (m_elapsed[c] == m_div[c] + 1) begin
          m_elapsed[c] = 0;
          m_tick[c] = 1;
          m_level[c] = mode[c] ? 1'b0 : !m_level[c];
          if (div_wr[c]) begin m_div[c] = din; m_pval[c] = din; end
          else if (m_pend[c]) m_div[c] = m_pval[c];
          m_pend[c] = 0;
        end else begin
          m_tick[c] = 0;
          if (mode[c]) m_level[c] = 0;
          if (div_wr[c]) begin m_pval[c] = din; m_pend[c] = 1; end
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [NUM_CH-1:0] act,
                       input logic [NUM_CH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: advance the model with the applied inputs, then compare.
  task automatic cycle(input string tag);
    logic [NUM_CH-1:0] e_clk, e_tick, e_upd;
    model_step();
    @(posedge clk);
    #1;
    for (int c = 0; c < NUM_CH; c++) begin
      e_clk[c] = m_level[c]; e_tick[c] = m_tick[c]; e_upd[c] = m_pend[c];
    end
    check({tag, ".model.clk_out"},  clk_out,  e_clk);
    check({tag, ".model.tick"},     tick,     e_tick);
    check({tag, ".model.upd_pend"}, upd_pend, e_upd);
  endtask

  task automatic set_in(input logic [1:0] e, input logic [1:0] m,
                        input logic [1:0] w, input int d0, input int d1);
    en = e; mode = m; div_wr = w;
    div_in = {CNT_W'(d1), CNT_W'(d0)};
  endtask

  task automatic do_reset();
    rst = 1'b0;
    set_in(2'b00, 2'b00, 2'b00, 0, 0);
    cycle("reset");
    rst = 1'b1;
  endtask

  typedef struct {
    logic [1:0] en, mode, wr;
    int         d0, d1;
    logic [1:0] e_clk, e_tick, e_upd;
  } vec_t;

  vec_t tbl [15];

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; sync_in = 1'b0;
    set_in(2'b00, 2'b00, 2'b00, 0, 0);

    // ---- reset state ----
    do_reset();
    check("reset.clk_out", clk_out, 2'b00);
    check("reset.tick", tick, 2'b00);
    check("reset.upd_pend", upd_pend, 2'b00);

    // ---- default divisor 3: 8-clk toggle period, tick every 4 ----
    set_in(2'b11, 2'b00, 2'b00, 0, 0);
    for (int k = 1; k <= 16; k++) begin
      cycle("period");
      check($sformatf("period.clk_out k=%0d", k), clk_out,
            ((k / 4) % 2 == 1) ? 2'b11 : 2'b00);
      check($sformatf("period.tick k=%0d", k), tick,
            (k % 4 == 0) ? 2'b11 : 2'b00);
    end

    // ---- table: N=0 tick mode written while disabled, write on wrap ----
    tbl[0] = '{2'b00, 2'b10, 2'b10, 0, 0, 2'b00, 2'b00, 2'b00};
    for (int r = 1; r <= 4; r++)
      tbl[r] = '{2'b10, 2'b10, 2'b00, 0, 0, 2'b00, 2'b10, 2'b00};
    for (int r = 5; r <= 7; r++)
      tbl[r] = '{2'b11, 2'b10, 2'b00, 0, 0, 2'b00, 2'b10, 2'b00};
    tbl[8] = '{2'b11, 2'b10, 2'b01, 5, 0, 2'b01, 2'b11, 2'b00};
    for (int r = 9; r <= 13; r++)
      tbl[r] = '{2'b11, 2'b10, 2'b00, 0, 0, 2'b01, 2'b10, 2'b00};
    tbl[14] = '{2'b11, 2'b10, 2'b00, 0, 0, 2'b00, 2'b11, 2'b00};

    do_reset();
    for (int r = 0; r < 15; r++) begin
      set_in(tbl[r].en, tbl[r].mode, tbl[r].wr, tbl[r].d0, tbl[r].d1);
      cycle("table");
      check($sformatf("table.clk_out r=%0d", r), clk_out, tbl[r].e_clk);
      check($sformatf("table.tick r=%0d", r), tick, tbl[r].e_tick);
      check($sformatf("table.upd_pend r=%0d", r), upd_pend, tbl[r].e_upd);
    end

    // ---- pending write of 9 while running at N=3 ----
    do_reset();
    set_in(2'b01, 2'b00, 2'b00, 0, 0);
    cycle("wr9");                                 // edge 1, cnt=1
    set_in(2'b01, 2'b00, 2'b01, 9, 0);
    cycle("wr9");                                 // edge 2
    check("wr9.pend_e2", upd_pend[0], 1'b1);
    set_in(2'b01, 2'b00, 2'b00, 0, 0);
    cycle("wr9");                                 // edge 3
    check("wr9.pend_e3", upd_pend[0], 1'b1);
    cycle("wr9");                                 // edge 4: wrap
    check("wr9.pend_e4", upd_pend[0], 1'b0);
    check("wr9.tick_e4", tick[0], 1'b1);
    check("wr9.clk_e4", clk_out[0], 1'b1);
    for (int k = 5; k <= 24; k++) begin
      cycle("wr9");
      check($sformatf("wr9.tick k=%0d", k), tick[0], (k == 14 || k == 24));
      check($sformatf("wr9.clk k=%0d", k), clk_out[0], (k < 14 || k >= 24));
    end

    // ---- reset mid-period discards a pending write ----
    cycle("rstmid");
    set_in(2'b01, 2'b00, 2'b01, 7, 0);
    cycle("rstmid");
    check("rstmid.pend_before", upd_pend[0], 1'b1);
    rst = 1'b0;
    set_in(2'b01, 2'b00, 2'b00, 0, 0);
    cycle("rstmid");
    check("rstmid.clk_out", clk_out, 2'b00);
    check("rstmid.tick", tick, 2'b00);
    check("rstmid.upd_pend", upd_pend, 2'b00);
    rst = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      cycle("rstmid");
      check($sformatf("rstmid.tick k=%0d", k), tick[0], (k == 4));
    end

`ifdef CLOCK_DIV_MULTI_PHASE_SYNC_EN
    // ---- phase sync: N=3 and N=5 realigned, ticks meet every 12 clks ----
    do_reset();
    set_in(2'b00, 2'b00, 2'b10, 0, 5);
    cycle("sync");
    set_in(2'b01, 2'b00, 2'b00, 0, 0);
    cycle("sync");
    cycle("sync");
    set_in(2'b11, 2'b00, 2'b00, 0, 0);
    cycle("sync");
    cycle("sync");
    sync_in = 1'b1;
    cycle("sync");
    check("sync.tick", tick, 2'b00);
    check("sync.clk_out", clk_out, 2'b00);
    sync_in = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      cycle("sync");
      check($sformatf("sync.tick k=%0d", k), tick,
            {1'(k % 6 == 0), 1'(k % 4 == 0)});
    end
`endif

    // ---- randomized run against the model ----
    do_reset();
    set_in(2'b11, 2'b00, 2'b00, 0, 0);
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 99) != 0);
      for (int c = 0; c < NUM_CH; c++) begin
        en[c]     = ($urandom_range(0, 9) != 0);
        div_wr[c] = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 19) == 0) mode[c] = 1'($urandom_range(0, 1));
      end
      div_in = {CNT_W'($urandom_range(0, 6)), CNT_W'($urandom_range(0, 6))};
`ifdef CLOCK_DIV_MULTI_PHASE_SYNC_EN
      sync_in = ($urandom_range(0, 49) == 0);
`endif
      cycle("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_div_multi.md
Name: clock_div_multi

Overview:
- Parametrised, multi-channel successor to the single fixed clock divider.
- NUM_CH independent channels share one system clock.
- Each channel has a runtime-programmable divisor, a per-channel mode (50% toggle clock or single-cycle tick), and an enable.
- Feeds the game's slow logic (claw motor stepping, display scan, debounce sampling) from the 100 MHz system clock.

Parameters:
- NUM_CH, 4, number of independent divider channels (1..16).
- CNT_W, 26, counter/divisor width in bits.
- DEF_DIV, 500000, divisor loaded into every channel at reset (must fit in CNT_W).

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  synchronous active-low reset; rst==0 on a clk rising edge resets the block.
- en  in  NUM_CH  per-channel run enable.
- mode  in  NUM_CH  per-channel mode: 0 = toggle (clk_out), 1 = tick only.
- div_wr  in  NUM_CH  per-channel one-cycle divisor write strobe.
- div_in  in  NUM_CH*CNT_W  flattened divisor values; channel i uses bits [i*CNT_W +: CNT_W].
- clk_out  out  NUM_CH  divided clock (registered).
- tick  out  NUM_CH  one-cycle pulse at each counter wrap (registered).
- upd_pend  out  NUM_CH  high while a written divisor is waiting to take effect.

Behaviour:
- Per-channel state: cnt[CNT_W], act_div, pend_div, pend flag, clk_out, tick. All registered; no combinational paths from inputs to outputs.
- Reset (rst==0 at posedge clk), all channels:
  - cnt=0, clk_out=0, tick=0, upd_pend=0
  - act_div=pend_div=DEF_DIV
  - Takes priority over every other input.
- Running (en[i]=1), with N=act_div:
  - If cnt==N: cnt<=0, tick<=1; if mode==0, clk_out<=~clk_out.
  - Otherwise: cnt<=cnt+1, tick<=0, clk_out holds.
  - Toggle mode period = 2*(N+1) clks, 50% duty. Tick period = N+1 clks, 1-clk high.
  - N=0: tick every clk; clk_out toggles every clk (clk/2).
- Mode 1: clk_out forced to 0 on the next clk. Tick still fires at every wrap in both modes.
- Mode change mid-run: takes effect next clk; cnt is not disturbed.
- Disabled (en[i]=0): cnt<=0, tick<=0, clk_out<=0. If upd_pend, act_div<=pend_div and upd_pend<=0. Re-enable starts with a full period (first tick N+1 clks after en rises).
- Divisor write (div_wr[i]=1, running):
  - pend_div<=div_in slice, upd_pend<=1.
  - At the next wrap: act_div<=pend_div, upd_pend<=0.
  - No mid-period change, so a smaller divisor cannot strand cnt above N.
- Simultaneous div_wr and wrap in the same clk: the new value goes straight to act_div; upd_pend stays 0.
- Second write before wrap: overwrites pend_div (last write wins).
- Write while disabled: act_div updated on the same edge; upd_pend stays 0.
- cnt never exceeds act_div. Counter wrap is by compare only; no modular overflow is reachable.
- Channels are fully independent; no cross-channel ordering.

Optional Feature:
- Macro: CLOCK_DIV_MULTI_PHASE_SYNC_EN.
- Defined:
  - Adds input port sync_in (1 bit).
  - sync_in==1 at posedge clk: every enabled channel sets cnt<=0, clk_out<=0, tick<=0, and applies any pending divisor.
  - This phase-aligns all channels.
  - Reset has priority over sync_in; sync_in has priority over wrap and div_wr on the same edge (the div_wr value is applied as active).
- Undefined: port absent; no phase-align logic.

Decomposition:
- Package clock_div_pkg holds:
  - MODE_TOGGLE=1'b0, MODE_TICK=1'b1
  - default CNT_W and DEF_DIV constants
  - SYS_CLK_HZ=100_000_000
  - a function computing the divisor for a desired frequency: SYS_CLK_HZ/(2*f)-1 for toggle mode.
- Sub-module clock_div_ch implements one channel. clock_div_multi is a generate loop over NUM_CH plus bus slicing.

Test Plan:
- NUM_CH=2, DEF_DIV=3, en=11, mode=00 after reset -> clk_out period 8 clks, 4 high/4 low. First toggle 4 clks after en. tick 1 clk every 4 clks.
- ch1 mode=1, div_in=0 written while disabled then enabled -> tick high every clk, clk_out stays 0, upd_pend[1] never asserts.
- ch0 running N=3, write 9 at cnt=1 -> upd_pend[0]=1 until the wrap 3 clks later. Next periods use N=9 (20-clk toggle period).
- Write lands exactly on the wrap clk -> act_div changes on that edge, upd_pend stays 0.
- Assert rst=0 for 1 clk mid-period with pending write -> all outputs 0, act_div=DEF_DIV, pending write discarded.
- With CLOCK_DIV_MULTI_PHASE_SYNC_EN, channels at N=3 and N=5 offset in phase, pulse sync_in -> both cnt=0 next clk. Ticks coincide every 12 clks.
